// File: rtl/logic_pkg.sv
// Shared op codes and the bitwise evaluation function for the vector logic pipeline.
// Operands are carried at MAX_WIDTH bits; callers zero-extend and slice to their width.
package logic_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND    = 3'd0;
    localparam op_t OP_OR     = 3'd1;
    localparam op_t OP_XOR    = 3'd2;
    localparam op_t OP_NAND   = 3'd3;
    localparam op_t OP_NOR    = 3'd4;
    localparam op_t OP_XNOR   = 3'd5;
    localparam op_t OP_NOT_A  = 3'd6;
    localparam op_t OP_PASS_A = 3'd7;

    function automatic logic [MAX_WIDTH-1:0] logic_eval(
        input op_t                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] y;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_NOT_A: y = ~a;
            default:  y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register stage carrying {valid, y, zero, ones}.
// An empty stage always loads from upstream, which is what collapses bubbles.
module logic_pipe_stage #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_y,
    input  logic             up_zero,
    input  logic             up_ones,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_y,
    output logic             dn_zero,
    output logic             dn_ones
);

    logic             advance;
    logic             load;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] y_d, y_q;
    logic             zero_d, zero_q;
    logic             ones_d, ones_q;

    always_comb begin
        advance = ~valid_q | dn_ready;
        load    = advance & up_valid;
        valid_d = advance ? up_valid : valid_q;
        // Data only moves on a real load so a stalled stage stays stable.
        y_d     = load ? up_y    : y_q;
        zero_d  = load ? up_zero : zero_q;
        ones_d  = load ? up_ones : ones_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    if (RESET_DATA) begin : g_rst_data
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                y_q    <= '0;
                zero_q <= 1'b0;
                ones_q <= 1'b0;
            end else begin
                y_q    <= y_d;
                zero_q <= zero_d;
                ones_q <= ones_d;
            end
        end
    end else begin : g_no_rst_data
        always_ff @(posedge clock) begin
            y_q    <= y_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
        end
    end

    assign up_ready = advance;
    assign dn_valid = valid_q;
    assign dn_y     = y_q;
    assign dn_zero  = zero_q;
    assign dn_ones  = ones_q;

endmodule

// File: rtl/logic_vec_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready handshake and zero/ones flags.
// WIDTH must not exceed logic_pkg::MAX_WIDTH.
module logic_vec_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones
);

    logic [MAX_WIDTH-1:0] a_ext, b_ext, y_ext;
    logic [WIDTH-1:0]     res;

    always_comb begin
        a_ext = MAX_WIDTH'(in_a);
        b_ext = MAX_WIDTH'(in_b);
        y_ext = logic_eval(op_t'(in_op), a_ext, b_ext);
        res   = y_ext[WIDTH-1:0];
    end

    if (WIDTH < MAX_WIDTH) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^y_ext[MAX_WIDTH-1:WIDTH];
    end

    // Index k is the input side of stage k; index STAGES is the output port.
    logic [STAGES:0]            vld;
    logic [STAGES:0]            rdy;
    logic [STAGES:0][WIDTH-1:0] ys;
    logic [STAGES:0]            zs;
    logic [STAGES:0]            os;

    assign vld[0]      = in_valid;
    assign ys[0]       = res;
    assign zs[0]       = ~|res;
    assign os[0]       = &res;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (k == STAGES - 1)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_y     (ys[k]),
            .up_zero  (zs[k]),
            .up_ones  (os[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_y     (ys[k+1]),
            .dn_zero  (zs[k+1]),
            .dn_ones  (os[k+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign out_y     = ys[STAGES];
    assign out_zero  = zs[STAGES];
    assign out_ones  = os[STAGES];

endmodule

// File: tb/tb_logic_vec_pipe.sv
// Bench for logic_vec_pipe: an 8-bit/2-stage instance and a 1-bit/1-stage instance,
// each watched by a truth-table reference model and an in-order scoreboard.
module tb_logic_vec_pipe;
    import logic_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic         in_valid, in_ready, out_valid, out_ready, out_zero, out_ones;
    logic [2:0]   in_op;
    logic [W-1:0] in_a, in_b, out_y;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, out_zero1, out_ones1;
    logic [2:0]   in_op1;
    logic [0:0]   in_a1, in_b1, out_y1;

    logic_vec_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero), .out_ones(out_ones)
    );

    logic_vec_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1), .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
        .out_zero(out_zero1), .out_ones(out_ones1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-op truth table indexed by {a_bit, b_bit}.
    function automatic logic [63:0] ref_eval(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b, input int w);
        logic [3:0]  tt [8];
        logic [63:0] y;
        tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        y = '0;
        for (int i = 0; i < w; i++) y[i] = tt[op][{a[i], b[i]}];
        return y;
    endfunction

    function automatic logic [63:0] all_ones(input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Scoreboard for the 8-bit instance, also checking stall stability.
    logic [63:0]  qa[$];
    logic         stall_a = 1'b0;
    logic [W-1:0] hold_a;
    always @(negedge clock) begin
        logic [63:0] e;
        if (!reset) begin
            qa.delete();
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold_y", out_y, hold_a);
            end
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra_out: got y=%0h want no output", out_y);
                end else begin
                    e = qa.pop_front();
                    check("sb_y", out_y, e);
                    check("sb_zero", out_zero, e == 0);
                    check("sb_ones", out_ones, e == all_ones(W));
                end
            end
            if (in_valid && in_ready) qa.push_back(ref_eval(in_op, in_a, in_b, W));
            stall_a = out_valid && !out_ready;
            hold_a  = out_y;
        end
    end

    logic [63:0] qb[$];
    always @(negedge clock) begin
        logic [63:0] e;
        if (!reset) begin
            qb.delete();
        end else begin
            if (out_valid1 && out_ready1) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb1_extra_out: got y=%0h want no output", out_y1);
                end else begin
                    e = qb.pop_front();
                    check("sb1_y", out_y1, e);
                    check("sb1_zero", out_zero1, e == 0);
                    check("sb1_ones", out_ones1, e == 1);
                end
            end
            if (in_valid1 && in_ready1) qb.push_back(ref_eval(in_op1, in_a1, in_b1, 1));
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, y;
        logic       zero, ones;
    } vec_t;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        vec_t        tab [11];
        logic [2:0]  t_op [8];
        logic [7:0]  t_a [8], t_b [8];
        int          n, outs, cycles;
        logic        fired;
        logic [63:0] ey;

        tab = '{
            '{OP_AND,    8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0},
            '{OP_OR,     8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0},
            '{OP_XOR,    8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0},
            '{OP_NAND,   8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0},
            '{OP_NOR,    8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0},
            '{OP_XNOR,   8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0},
            '{OP_NOT_A,  8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0},
            '{OP_PASS_A, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0},
            '{OP_NAND,   8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0},
            '{OP_NOR,    8'h00, 8'h00, 8'hFF, 1'b0, 1'b1},
            '{OP_XOR,    8'h0F, 8'h0F, 8'h00, 1'b1, 1'b0}
        };

        reset = 1'b0;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_op1 = '0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_flags", {out_zero, out_ones}, 0);
        check("rst1_out_valid", out_valid1, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("in_ready_after_reset", in_ready, 1);

        // Every op plus flag corners, with exact two-cycle latency.
        for (int i = 0; i < 11; i++) begin
            cyc();
            drive(tab[i].op, tab[i].a, tab[i].b);
            cyc();
            in_valid = 1'b0;
            @(negedge clock);
            check($sformatf("tab%0d_not_yet", i), out_valid, 0);
            @(negedge clock);
            check($sformatf("tab%0d_valid", i), out_valid, 1);
            check($sformatf("tab%0d_y", i), out_y, tab[i].y);
            check($sformatf("tab%0d_zero", i), out_zero, tab[i].zero);
            check($sformatf("tab%0d_ones", i), out_ones, tab[i].ones);
        end

        // Back-to-back under backpressure, then drain in order.
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t_op[i] = 3'(i);
            t_a[i]  = 8'($urandom);
            t_b[i]  = 8'($urandom);
        end
        n = 0;
        repeat (6) begin
            drive(t_op[n], t_a[n], t_b[n]);
            @(negedge clock);
            fired = in_ready;
            cyc();
            if (fired && n < 7) n++;
        end
        check("bp_accepts", n, 2);
        @(negedge clock);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_first", out_y, ref_eval(t_op[0], t_a[0], t_b[0], W));
        cyc();
        out_ready = 1'b1;
        outs = 0;
        cycles = 0;
        while (outs < 6 && cycles < 20) begin
            if (n < 6) drive(t_op[n], t_a[n], t_b[n]);
            else in_valid = 1'b0;
            @(negedge clock);
            if (out_valid) outs++;
            fired = in_valid && in_ready;
            cyc();
            if (fired && n < 7) n++;
            cycles++;
        end
        in_valid = 1'b0;
        check("drain_all_in", n, 6);
        check("drain_cycles", cycles, 6);

        // Bubble collapse.
        cyc();
        out_ready = 1'b0;
        drive(OP_XOR, 8'h3C, 8'h81);
        cyc();
        in_valid = 1'b0;
        cyc();
        drive(OP_OR, 8'h12, 8'h40);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clock);
        check("bubble_in_ready", in_ready, 0);
        check("bubble_out_valid", out_valid, 1);
        check("bubble_first_y", out_y, ref_eval(OP_XOR, 8'h3C, 8'h81, W));
        cyc();
        out_ready = 1'b1;
        @(negedge clock);
        check("bubble_out0", out_valid, 1);
        @(negedge clock);
        check("bubble_out1", out_valid, 1);
        check("bubble_out1_y", out_y, ref_eval(OP_OR, 8'h12, 8'h40, W));
        @(negedge clock);
        check("bubble_empty", out_valid, 0);

        // Reset mid-stream.
        cyc();
        out_ready = 1'b0;
        drive(OP_OR, 8'h3C, 8'h01);
        cyc();
        drive(OP_AND, 8'hF0, 8'h30);
        cyc();
        in_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_valid", out_valid, 1);
        cyc();
        #1 reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_y", out_y, 0);
        check("midrst_flags", {out_zero, out_ones}, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_empty", out_valid, 0);
        cyc();
        drive(OP_XNOR, 8'h96, 8'h0F);
        cyc();
        in_valid = 1'b0;
        @(negedge clock);
        check("post_rst_lat1", out_valid, 0);
        @(negedge clock);
        check("post_rst_lat2", out_valid, 1);
        check("post_rst_y", out_y, ref_eval(OP_XNOR, 8'h96, 8'h0F, W));

        // Random traffic on the wide instance.
        cyc();
        repeat (3000) begin
            in_valid  = ($urandom % 4) != 0;
            in_op     = 3'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && qa.size() != 0; k++) cyc();
        check("rand_drain", qa.size(), 0);

        // Single-bit, single-stage NAND truth table at latency 1.
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid1 = 1'b1;
            in_op1    = OP_NAND;
            in_a1     = 1'(i);
            in_b1     = 1'(i >> 1);
            cyc();
            in_valid1 = 1'b0;
            @(negedge clock);
            ey = (i == 3) ? 64'd0 : 64'd1;
            check($sformatf("nand1_%0d_valid", i), out_valid1, 1);
            check($sformatf("nand1_%0d_y", i), out_y1, ey);
        end
        cyc();
        repeat (2000) begin
            in_valid1  = ($urandom % 4) != 0;
            in_op1     = 3'($urandom);
            in_a1      = 1'($urandom);
            in_b1      = 1'($urandom);
            out_ready1 = ($urandom % 3) != 0;
            cyc();
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        for (int k = 0; k < 20 && qb.size() != 0; k++) cyc();
        check("rand1_drain", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
